// File: rtl/clk_divider_by_3_pkg.sv
// Shared constants and helpers for the integer clock divider.
`timescale 1ns/100ps
package clk_divider_by_3_pkg;

  localparam int unsigned DIV_DEFAULT = 3;

  function automatic int unsigned cnt_width(input int unsigned d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  function automatic bit is_odd(input int unsigned d);
    return d[0];
  endfunction

endpackage

// File: rtl/clk_divider_by_3_counter.sv
// Modulo-DIV up-counter with asynchronous active-low clear.
`timescale 1ns/100ps
module div_mod_counter
  import clk_divider_by_3_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  localparam int unsigned CW = cnt_width(DIV)
) (
  input  logic          clk,
  input  logic          rst_h,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  always_ff @(posedge clk or negedge rst_h) begin
    if (!rst_h) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_divider_by_3.sv
// 50% duty integer clock divider; odd ratios stretch the
// high phase by half a period with a falling-edge flop.
`timescale 1ns/100ps
module clk_divider_by_3
  import clk_divider_by_3_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  localparam int unsigned CW = cnt_width(DIV)
) (
  input  logic clk,
  input  logic rst_h,
  output logic clk_div
);

  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] cnt;
  logic          pos_q;
  logic          neg_q;

  if (DIV < 2) begin : g_bad_div
    $error("clk_divider_by_3: DIV must be >= 2");
  end

  div_mod_counter #(.DIV(DIV)) u_cnt (
    .clk   (clk),
    .rst_h (rst_h),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge rst_h) begin
    if (!rst_h) begin
      pos_q <= 1'b0;
    end else begin
      pos_q <= (cnt < HALF);
    end
  end

  // pos_q and neg_q overlap by half a period, so the OR is glitch-free
  if (is_odd(DIV)) begin : g_odd
    always_ff @(negedge clk or negedge rst_h) begin
      if (!rst_h) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= pos_q;
      end
    end
    assign clk_div = pos_q | neg_q;
  end else begin : g_even
    assign neg_q   = 1'b0;
    assign clk_div = pos_q;
  end

endmodule

// File: tb/tb_clk_divider_by_3.sv
// Directed bench: DIV=3 timing, async reset, DIV=4 and DIV=5 ratios.
`timescale 1ns/100ps
module tb_clk_divider_by_3;

  logic clk;
  logic rst3, rst4, rst5;
  logic div3, div4, div5;

  int errors;
  int checks;

  int      rises;
  bit      counting;
  bit      have_last;
  realtime last_t;
  realtime min_w;
  realtime max_w;

  clk_divider_by_3 #(.DIV(3)) dut3 (
    .clk     (clk),
    .rst_h   (rst3),
    .clk_div (div3)
  );

  clk_divider_by_3 #(.DIV(4)) dut4 (
    .clk     (clk),
    .rst_h   (rst4),
    .clk_div (div4)
  );

  clk_divider_by_3 #(.DIV(5)) dut5 (
    .clk     (clk),
    .rst_h   (rst5),
    .clk_div (div5)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(div3) begin
    if (counting) begin
      if (div3 === 1'b1) rises++;
      if (have_last) begin
        if ($realtime - last_t < min_w) min_w = $realtime - last_t;
        if ($realtime - last_t > max_w) max_w = $realtime - last_t;
      end
      have_last = 1'b1;
      last_t    = $realtime;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h",
             tag, $realtime, obs, exp);
    end
  endtask

  task automatic at(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rises     = 0;
    counting  = 1'b0;
    have_last = 1'b0;
    last_t    = 0.0;
    min_w     = 1000.0;
    max_w     = 0.0;
    rst3 = 1'b0;
    rst4 = 1'b0;
    rst5 = 1'b0;

    // reset hold: everything low while clk toggles
    for (int i = 0; i < 4; i++) begin
      at(0.5 + i);
      chk("rst_div3", 32'(div3), 32'd0);
      chk("rst_cnt3", 32'(dut3.cnt), 32'd0);
      chk("rst_div4", 32'(div4), 32'd0);
      chk("rst_div5", 32'(div5), 32'd0);
    end

    // DIV=3 release at t=4, first rise at R1=5
    at(4.0);
    rst3     = 1'b1;
    counting = 1'b1;
    at(4.5);
    chk("d3_pre_r1", 32'(div3), 32'd0);
    for (int k = 0; k < 15; k++) begin
      at(5.5 + 6 * k);
      chk("d3_hi_start", 32'(div3), 32'd1);
      at(7.5 + 6 * k);
      chk("d3_hi_end", 32'(div3), 32'd1);
      at(8.5 + 6 * k);
      chk("d3_lo_start", 32'(div3), 32'd0);
      at(10.5 + 6 * k);
      chk("d3_lo_end", 32'(div3), 32'd0);
    end

    // frequency window t=4..100: rises at 5,11,...,95
    at(100.0);
    counting = 1'b0;
    at(100.5);
    chk("d3_rise_cnt", 32'(rises), 32'd16);
    chk("d3_min_w", 32'(int'(min_w * 10)), 32'd30);
    chk("d3_max_w", 32'(int'(max_w * 10)), 32'd30);

    // async reset while div3 high (high over 107..110)
    at(107.4);
    chk("d3_before_rst", 32'(div3), 32'd1);
    at(107.5);
    rst3 = 1'b0;
    #0.1;
    chk("d3_async_rst", 32'(div3), 32'd0);
    chk("d3_async_cnt", 32'(dut3.cnt), 32'd0);
    at(108.5);
    chk("d3_rst_hold_a", 32'(div3), 32'd0);
    at(109.5);
    chk("d3_rst_hold_b", 32'(div3), 32'd0);
    at(110.0);
    rst3 = 1'b1;
    at(110.5);
    chk("d3_re_pre_r1", 32'(div3), 32'd0);
    at(111.5);
    chk("d3_re_r1", 32'(div3), 32'd1);
    at(113.5);
    chk("d3_re_hi_end", 32'(div3), 32'd1);
    at(114.5);
    chk("d3_re_lo", 32'(div3), 32'd0);
    at(116.5);
    chk("d3_re_lo_end", 32'(div3), 32'd0);
    at(117.5);
    chk("d3_re_r4", 32'(div3), 32'd1);

    // DIV=4 release at t=120, R1=121, period 8
    at(120.0);
    rst4 = 1'b1;
    at(120.5);
    chk("d4_pre_r1", 32'(div4), 32'd0);
    for (int k = 0; k < 4; k++) begin
      at(121.5 + 8 * k);
      chk("d4_hi_start", 32'(div4), 32'd1);
      chk("d4_neg_q", 32'(dut4.neg_q), 32'd0);
      at(124.5 + 8 * k);
      chk("d4_hi_end", 32'(div4), 32'd1);
      at(125.5 + 8 * k);
      chk("d4_lo_start", 32'(div4), 32'd0);
      chk("d4_neg_q", 32'(dut4.neg_q), 32'd0);
      at(128.5 + 8 * k);
      chk("d4_lo_end", 32'(div4), 32'd0);
    end

    // DIV=5 release at t=160, R1=161, falls at falling edge t=166
    at(160.0);
    rst5 = 1'b1;
    at(160.5);
    chk("d5_pre_r1", 32'(div5), 32'd0);
    for (int k = 0; k < 4; k++) begin
      at(161.5 + 10 * k);
      chk("d5_hi_start", 32'(div5), 32'd1);
      at(165.5 + 10 * k);
      chk("d5_hi_end", 32'(div5), 32'd1);
      at(166.5 + 10 * k);
      chk("d5_lo_start", 32'(div5), 32'd0);
      at(170.5 + 10 * k);
      chk("d5_lo_end", 32'(div5), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
